// File: rtl/halut_collector_pkg.sv
// Shared types and constants for the halut result collector.
package halut_collector_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    typedef logic [31:0] result_t;

    localparam int ROW_CNT_WIDTH = 16;

endpackage

// File: rtl/halut_collector_bank.sv
// One M-entry row buffer with per-index fill bitmap; lanes write in ascending order so the higher lane wins.
// Latency: writes visible on rd_data_o the cycle after the edge; all_full_o/dup_o reflect this cycle's writes.
// Backpressure: none, the owner gates we_i.
module halut_collector_bank #(
    parameter int M     = 32,
    parameter int Lanes = 2,
    parameter int AW    = $clog2(M),
    parameter int DW    = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic [Lanes-1:0]          we_i,
    input  logic [Lanes-1:0][AW-1:0]  addr_i,
    input  logic [Lanes-1:0][DW-1:0]  data_i,
    input  logic [AW-1:0]             rd_addr_i,
    output logic [DW-1:0]             rd_data_o,
    output logic                      all_full_o,
    output logic                      dup_o
);

    logic [DW-1:0] mem_q [M];
    logic [DW-1:0] mem_d [M];
    logic [M-1:0]  bitmap_q;
    logic [M-1:0]  bitmap_d;

    always_comb begin
        mem_d    = mem_q;
        bitmap_d = bitmap_q;
        dup_o    = 1'b0;
        // Checking bitmap_d rather than bitmap_q also catches two lanes hitting one index this cycle.
        for (int l = 0; l < Lanes; l++) begin
            if (we_i[l]) begin
                if (bitmap_d[addr_i[l]]) begin
                    dup_o = 1'b1;
                end
                mem_d[addr_i[l]]    = data_i[l];
                bitmap_d[addr_i[l]] = 1'b1;
            end
        end
        all_full_o = &bitmap_d;
        if (clr_i) begin
            bitmap_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bitmap_q <= '0;
        end else begin
            bitmap_q <= bitmap_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/halut_result_collector.sv
// Double-buffered row collector: fills one bank from decoder lanes, drains the other in index order.
// Latency: out_valid_o rises the cycle after the completing write. Optional HALUT_COLLECTOR_STALL_CNT_EN adds stall_cycles_o.
// Backpressure: out_ready_i stalls the drain; lanes cannot be stalled, so writes with no free bank are dropped and flagged.
module halut_result_collector
    import halut_collector_pkg::*;
#(
    parameter int M            = 32,
    parameter int DecoderUnits = 16,
    parameter int DecUnitsX    = M / DecoderUnits,
    parameter int ResultWidth  = 32,
    parameter int MAddrWidth   = $clog2(M),
    parameter int RowCntWidth  = ROW_CNT_WIDTH
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [DecUnitsX-1:0]                   valid_i,
    input  logic [DecUnitsX-1:0][MAddrWidth-1:0]   m_addr_i,
    input  logic [DecUnitsX-1:0][ResultWidth-1:0]  result_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [ResultWidth-1:0]                 out_data_o,
    output logic [MAddrWidth-1:0]                  out_idx_o,
    output logic                                   out_last_o,
    output logic [RowCntWidth-1:0]                 rows_done_o,
    input  logic                                   clr_err_i,
    output logic                                   err_overflow_o,
    output logic                                   err_dup_o
`ifdef HALUT_COLLECTOR_STALL_CNT_EN
    ,
    output logic [31:0]                            stall_cycles_o
`endif
);

    bank_state_e              bank_state_q [2];
    bank_state_e              bank_state_d [2];
    drain_state_e             drain_q, drain_d;
    logic                     fill_bank_q, fill_bank_d;
    logic                     drain_bank_q, drain_bank_d;
    logic [MAddrWidth-1:0]    idx_q, idx_d;
    logic [RowCntWidth-1:0]   rows_q, rows_d;
    logic                     err_ovf_q, err_ovf_d;
    logic                     err_dup_q, err_dup_d;

    logic [DecUnitsX-1:0]     lane_we;
    logic [DecUnitsX-1:0]     bank_we [2];
    logic                     bank_clr [2];
    logic [ResultWidth-1:0]   bank_rd [2];
    logic                     bank_full [2];
    logic                     bank_dup [2];
    logic                     writable;
    logic                     xfer;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = (fill_bank_q == 1'(b)) ? lane_we : '0;

        halut_collector_bank #(
            .M     (M),
            .Lanes (DecUnitsX),
            .AW    (MAddrWidth),
            .DW    (ResultWidth)
        ) u_bank (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clr_i      (bank_clr[b]),
            .we_i       (bank_we[b]),
            .addr_i     (m_addr_i),
            .data_i     (result_i),
            .rd_addr_i  (idx_q),
            .rd_data_o  (bank_rd[b]),
            .all_full_o (bank_full[b]),
            .dup_o      (bank_dup[b])
        );
    end

    assign out_valid_o    = (drain_q == DRAIN);
    assign out_idx_o      = idx_q;
    assign out_last_o     = out_valid_o && (idx_q == MAddrWidth'(M - 1));
    assign out_data_o     = out_valid_o ? bank_rd[drain_bank_q] : '0;
    assign rows_done_o    = rows_q;
    assign err_overflow_o = err_ovf_q;
    assign err_dup_o      = err_dup_q;

    always_comb begin
        bank_state_d = bank_state_q;
        drain_d      = drain_q;
        fill_bank_d  = fill_bank_q;
        drain_bank_d = drain_bank_q;
        idx_d        = idx_q;
        rows_d       = rows_q;
        bank_clr[0]  = 1'b0;
        bank_clr[1]  = 1'b0;

        writable = (bank_state_q[fill_bank_q] == EMPTY) || (bank_state_q[fill_bank_q] == FILLING);
        lane_we  = writable ? valid_i : '0;
        xfer     = out_valid_o && out_ready_i;

        if (|lane_we) begin
            if (bank_full[fill_bank_q]) begin
                bank_state_d[fill_bank_q] = FULL;
                fill_bank_d               = ~fill_bank_q;
            end else begin
                bank_state_d[fill_bank_q] = FILLING;
            end
        end

        // Drain decisions look at bank_state_d so a row completing this cycle is claimed without a bubble.
        case (drain_q)
            IDLE: begin
                if (bank_state_d[drain_bank_q] == FULL) begin
                    bank_state_d[drain_bank_q] = DRAINING;
                    drain_d                    = DRAIN;
                    idx_d                      = '0;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    if (out_last_o) begin
                        bank_state_d[drain_bank_q] = EMPTY;
                        bank_clr[drain_bank_q]     = 1'b1;
                        drain_bank_d               = ~drain_bank_q;
                        rows_d                     = rows_q + 1'b1;
                        idx_d                      = '0;
                        if (bank_state_d[~drain_bank_q] == FULL) begin
                            bank_state_d[~drain_bank_q] = DRAINING;
                        end else begin
                            drain_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: drain_d = IDLE;
        endcase

        err_ovf_d = (err_ovf_q && !clr_err_i) || ((|valid_i) && !writable);
        err_dup_d = (err_dup_q && !clr_err_i) || bank_dup[0] || bank_dup[1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bank_state_q[0] <= EMPTY;
            bank_state_q[1] <= EMPTY;
            drain_q         <= IDLE;
            fill_bank_q     <= 1'b0;
            drain_bank_q    <= 1'b0;
            idx_q           <= '0;
            rows_q          <= '0;
            err_ovf_q       <= 1'b0;
            err_dup_q       <= 1'b0;
        end else begin
            bank_state_q <= bank_state_d;
            drain_q      <= drain_d;
            fill_bank_q  <= fill_bank_d;
            drain_bank_q <= drain_bank_d;
            idx_q        <= idx_d;
            rows_q       <= rows_d;
            err_ovf_q    <= err_ovf_d;
            err_dup_q    <= err_dup_d;
        end
    end

`ifdef HALUT_COLLECTOR_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (clr_err_i) begin
            stall_d = '0;
        end else if (out_valid_o && !out_ready_i && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles_o = stall_q;
`endif

endmodule
